// File: rtl/mul_job_sched_if.sv
// mul_job_sched_if: requester-side job handshake for mul_job_sched.
//
// Signals (one set per requester, suffix _0 / _1):
//   req0/req1           job request, held high until the matching done pulse
//   adr1_x, adr2_x      ROM addresses of operand A and operand B
//   adr_ram_x           RAM destination address of the product
//   done0/done1         one-cycle completion pulse back to the requester
//
// Modports: master = requester side, slave = scheduler side.
interface mul_job_sched_if #(
  parameter int AW = 3
);
  logic          req0;
  logic          req1;
  logic [AW-1:0] adr1_0;
  logic [AW-1:0] adr2_0;
  logic [AW-1:0] adr_ram_0;
  logic [AW-1:0] adr1_1;
  logic [AW-1:0] adr2_1;
  logic [AW-1:0] adr_ram_1;
  logic          done0;
  logic          done1;

  modport master (
    output req0, req1, adr1_0, adr2_0, adr_ram_0, adr1_1, adr2_1, adr_ram_1,
    input  done0, done1
  );

  modport slave (
    input  req0, req1, adr1_0, adr2_0, adr_ram_0, adr1_1, adr2_1, adr_ram_1,
    output done0, done1
  );
endinterface

// File: rtl/mul_job_sched.sv
// mul_job_sched: round-robin scheduler and sequencer for the shared
// ROM -> multiplier -> RAM datapath. Two requesters each submit a job
// (operand A address, operand B address, RAM destination). One job runs at a
// time: read both operands from the synchronous ROM, register their product,
// write it to RAM, then pulse the owner's done.
//
// Ports:
//   clk, rst        clock (rising edge) and asynchronous active-high reset
//   jobs            mul_job_sched_if.slave: req/addresses in, done out
//   rom_adr         ROM read address (data returns on the following cycle)
//   rom_data        ROM read data
//   ram_we/ram_adr/ram_din   RAM write port, active only in WR
//   product         last registered product (2*DW bits, unsigned)
//   st_out          current state encoding
//   job_cnt         completed-job counter, only when MULJOB_CNT_EN is defined
//
// Optional feature: define MULJOB_CNT_EN to add the 8-bit wrapping job_cnt
// output. Without it there is no counter and no job_cnt port.
module mul_job_sched #(
  parameter int DW = 4,
  parameter int AW = 3
) (
  input  logic            clk,
  input  logic            rst,
  mul_job_sched_if.slave  jobs,
  output logic [AW-1:0]   rom_adr,
  input  logic [DW-1:0]   rom_data,
  output logic            ram_we,
  output logic [AW-1:0]   ram_adr,
  output logic [2*DW-1:0] ram_din,
  output logic [2*DW-1:0] product,
  output logic [3:0]      st_out
`ifdef MULJOB_CNT_EN
  ,
  output logic [7:0]      job_cnt
`endif
);

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    RD1   = 4'd1,
    RD2   = 4'd2,
    LATCH = 4'd3,
    MUL   = 4'd4,
    WR    = 4'd5,
    DONE  = 4'd6
  } state_t;

  state_t        state;
  state_t        state_next;
  logic          own;      // id of the requester whose job is in flight
  logic          last;     // id of the most recently granted requester
  logic          win;      // id that would be granted this cycle
  logic          any_req;
  logic [AW-1:0] a1_q;
  logic [AW-1:0] a2_q;
  logic [AW-1:0] ar_q;
  logic [DW-1:0] op1;
  logic [DW-1:0] op2;

  assign any_req = jobs.req0 | jobs.req1;
  assign st_out  = state;

  // On a tie the requester that was not served last wins; otherwise the
  // single active requester wins (req1 alone -> 1, req0 alone -> 0).
  assign win = (jobs.req0 & jobs.req1) ? ~last : jobs.req1;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = IDLE;
    rom_adr    = '0;
    ram_we     = 1'b0;
    ram_adr    = '0;
    ram_din    = '0;
    jobs.done0 = 1'b0;
    jobs.done1 = 1'b0;
    case (state)
      IDLE:  state_next = any_req ? RD1 : IDLE;
      RD1: begin
        rom_adr    = a1_q;
        state_next = RD2;
      end
      RD2: begin
        rom_adr    = a2_q;
        state_next = LATCH;
      end
      LATCH: state_next = MUL;
      MUL:   state_next = WR;
      WR: begin
        ram_we     = 1'b1;
        ram_adr    = ar_q;
        ram_din    = product;
        state_next = DONE;
      end
      DONE: begin
        jobs.done0 = ~own;
        jobs.done1 = own;
        state_next = IDLE;
      end
      default: state_next = IDLE;  // unused encodings recover to IDLE
    endcase
  end

  // Datapath registers. Reset clears everything so an aborted job leaves no
  // trace in product or the latched job fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      own     <= 1'b0;
      last    <= 1'b1;  // requester 0 wins the first tie
      a1_q    <= '0;
      a2_q    <= '0;
      ar_q    <= '0;
      op1     <= '0;
      op2     <= '0;
      product <= '0;
`ifdef MULJOB_CNT_EN
      job_cnt <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (any_req) begin
          own  <= win;
          last <= win;
          a1_q <= win ? jobs.adr1_1    : jobs.adr1_0;
          a2_q <= win ? jobs.adr2_1    : jobs.adr2_0;
          ar_q <= win ? jobs.adr_ram_1 : jobs.adr_ram_0;
        end
        // ROM data lags the address by one cycle: operand A (addressed in
        // RD1) arrives during RD2, operand B (addressed in RD2) during LATCH.
        RD2:   op1 <= rom_data;
        LATCH: op2 <= rom_data;
        MUL:   product <= {{DW{1'b0}}, op1} * {{DW{1'b0}}, op2};
`ifdef MULJOB_CNT_EN
        DONE:  job_cnt <= job_cnt + 8'd1;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_job_sched.sv
module tb_mul_job_sched;
  localparam int DW = 4;
  localparam int AW = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [AW-1:0]   rom_adr;
  logic [DW-1:0]   rom_data;
  logic            ram_we;
  logic [AW-1:0]   ram_adr;
  logic [2*DW-1:0] ram_din;
  logic [2*DW-1:0] product;
  logic [3:0]      st_out;
`ifdef MULJOB_CNT_EN
  logic [7:0]      job_cnt;
`endif

  int errors = 0;
  int checks = 0;

  mul_job_sched_if #(.AW(AW)) jif ();

  mul_job_sched #(.DW(DW), .AW(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .jobs     (jif),
    .rom_adr  (rom_adr),
    .rom_data (rom_data),
    .ram_we   (ram_we),
    .ram_adr  (ram_adr),
    .ram_din  (ram_din),
    .product  (product),
    .st_out   (st_out)
`ifdef MULJOB_CNT_EN
    ,
    .job_cnt  (job_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous ROM model: data valid the cycle after the address.
  int rom [8];
  always @(posedge clk) rom_data <= 4'(rom[rom_adr]);

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // The RAM write and the done pulse never share a cycle, and at most one
  // of them is high at a time.
  always @(negedge clk) begin
    if (ram_we || jif.done0 || jif.done1)
      check("we_done_excl", int'(ram_we) + int'(jif.done0) + int'(jif.done1), 1);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic set_job(input int id, input int a1, input int a2, input int ar);
    if (id == 0) begin
      jif.adr1_0 = 3'(a1); jif.adr2_0 = 3'(a2); jif.adr_ram_0 = 3'(ar); jif.req0 = 1'b1;
    end else begin
      jif.adr1_1 = 3'(a1); jif.adr2_1 = 3'(a2); jif.adr_ram_1 = 3'(ar); jif.req1 = 1'b1;
    end
  endtask

  task automatic drop(input int id);
    if (id == 0) jif.req0 = 1'b0;
    else         jif.req1 = 1'b0;
  endtask

  // Leaves the bench one time unit after a rising edge, DUT idle.
  task automatic do_reset();
    #1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Waits for a done pulse, counting negedges; records any RAM write seen.
  task automatic wait_done(input int budget, output int id, output int lat,
                           output int wadr, output int wdin, output int wcnt);
    int c;
    id = -1; lat = 0; wadr = 0; wdin = 0; wcnt = 0; c = 0;
    while (id < 0 && c < budget) begin
      @(negedge clk);
      c++;
      if (ram_we) begin
        wcnt++; wadr = int'(ram_adr); wdin = int'(ram_din);
      end
      if (jif.done0 || jif.done1) begin
        id  = jif.done1 ? 1 : 0;
        lat = c;
      end
    end
  endtask

  task automatic serve(input string name, input int exp_id, input int exp_adr,
                       input int exp_din, input int exp_lat);
    int id, lat, wadr, wdin, wcnt;
    wait_done(40, id, lat, wadr, wdin, wcnt);
    check({name, "_done_id"}, id, exp_id);
    check({name, "_latency"}, lat, exp_lat);
    check({name, "_writes"}, wcnt, 1);
    check({name, "_ram_adr"}, wadr, exp_adr);
    check({name, "_ram_din"}, wdin, exp_din);
  endtask

  task automatic wait_st(input int target, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (int'(st_out) != target && n < budget);
    check("reach_state", int'(st_out), target);
  endtask

  task automatic check_zero_outputs(input string name);
    check({name, "_st_out"}, int'(st_out), 0);
    check({name, "_ram_we"}, int'(ram_we), 0);
    check({name, "_rom_adr"}, int'(rom_adr), 0);
    check({name, "_ram_adr"}, int'(ram_adr), 0);
    check({name, "_ram_din"}, int'(ram_din), 0);
    check({name, "_product"}, int'(product), 0);
    check({name, "_done"}, int'({jif.done1, jif.done0}), 0);
  endtask

  typedef struct {
    int id;
    int a1;
    int a2;
    int ar;
    int exp_din;  // rom[a1]*rom[a2] with rom[i]=i+1
  } vec_t;

  // Single job with a full cycle-by-cycle check. Called with DUT idle and
  // the next rising edge being the grant edge.
  task automatic run_vec(input int idx, input vec_t v);
    string tag;
    int exp_st, exp_rom;
    tag = $sformatf("vec%0d", idx);
    set_job(v.id, v.a1, v.a2, v.ar);
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk);
      if (k == 7) begin
        #1;
        drop(v.id);
      end
      @(negedge clk);
      exp_st  = (k < 7) ? k : 0;
      exp_rom = (k == 1) ? v.a1 : (k == 2) ? v.a2 : 0;
      check({tag, "_st_out"}, int'(st_out), exp_st);
      check({tag, "_rom_adr"}, int'(rom_adr), exp_rom);
      check({tag, "_ram_we"}, int'(ram_we), (k == 5) ? 1 : 0);
      check({tag, "_done"}, int'({jif.done1, jif.done0}), (k == 6) ? (v.id == 1 ? 2 : 1) : 0);
      if (k == 5) begin
        check({tag, "_ram_adr"}, int'(ram_adr), v.ar);
        check({tag, "_ram_din"}, int'(ram_din), v.exp_din);
      end
      if (k >= 5) check({tag, "_product"}, int'(product), v.exp_din);
    end
  endtask

  initial begin
    vec_t vecs [5];
    int   last_m;
    int   pat, first, second;
    int   a1 [2];
    int   a2 [2];
    int   ar [2];

    vecs[0] = '{id: 0, a1: 1, a2: 2, ar: 5, exp_din: 6};
    vecs[1] = '{id: 1, a1: 3, a2: 4, ar: 2, exp_din: 20};
    vecs[2] = '{id: 0, a1: 0, a2: 7, ar: 0, exp_din: 8};
    vecs[3] = '{id: 1, a1: 7, a2: 7, ar: 7, exp_din: 64};
    vecs[4] = '{id: 0, a1: 5, a2: 0, ar: 6, exp_din: 6};

    for (int i = 0; i < 8; i++) rom[i] = i + 1;
    jif.req0 = 1'b0; jif.req1 = 1'b0;
    jif.adr1_0 = '0; jif.adr2_0 = '0; jif.adr_ram_0 = '0;
    jif.adr1_1 = '0; jif.adr2_1 = '0; jif.adr_ram_1 = '0;
    rst = 1'b1;
    #1;
    check_zero_outputs("reset");
`ifdef MULJOB_CNT_EN
    check("reset_job_cnt", int'(job_cnt), 0);
`endif
    do_reset();

    // Simultaneous requests right after reset: 0 first, then alternation.
    set_job(0, 2, 5, 7);
    set_job(1, 4, 6, 1);
    serve("tie0", 0, 7, 18, 7);
    serve("tie1", 1, 1, 35, 7);
    serve("tie2", 0, 7, 18, 7);
    serve("tie3", 1, 1, 35, 7);
    @(posedge clk); #1;
    drop(0); drop(1);

    // Table-driven single jobs.
    for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);
    @(posedge clk); #1;

    // Maximum operands: 15*15 must not truncate.
    rom[6] = 15; rom[7] = 15;
    set_job(0, 6, 7, 2);
    serve("max", 0, 2, 225, 7);
    @(posedge clk); #1;
    drop(0);
    rom[6] = 7; rom[7] = 8;

    // Destination change while in RD2 must not redirect the write.
    set_job(0, 3, 4, 5);
    wait_st(2, 10);
    jif.adr_ram_0 = 3'd3;
    serve("adr_chg", 0, 5, 20, 4);
    @(posedge clk); #1;
    drop(0);

    // Asynchronous reset while in MUL: outputs clear at once, job dropped,
    // held request re-served afterwards.
    set_job(0, 1, 2, 5);
    wait_st(4, 10);
    check("pre_rst_product", int'(product), 20);
    #2;
    rst = 1'b1;
    #1;
    check_zero_outputs("midrst");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst_hold_we", int'(ram_we), 0);
      check("midrst_hold_done", int'({jif.done1, jif.done0}), 0);
      check("midrst_hold_st", int'(st_out), 0);
    end
    #2;
    rst = 1'b0;
    serve("rerun", 0, 5, 6, 6);
    @(posedge clk); #1;
    drop(0);

    // Randomized episodes against a round-robin reference model.
    do_reset();
    last_m = 1;
    for (int ep = 0; ep < 30; ep++) begin
      pat = $urandom_range(1, 3);
      for (int r = 0; r < 2; r++) begin
        a1[r] = $urandom_range(0, 7);
        a2[r] = $urandom_range(0, 7);
        ar[r] = $urandom_range(0, 7);
        if (pat[r]) set_job(r, a1[r], a2[r], ar[r]);
      end
      if (pat == 3) begin
        first  = (last_m == 0) ? 1 : 0;
        second = 1 - first;
      end else begin
        first  = (pat == 2) ? 1 : 0;
        second = -1;
      end
      serve($sformatf("rnd%0d_a", ep), first, ar[first], rom[a1[first]] * rom[a2[first]], 7);
      @(posedge clk); #1;
      drop(first);
      last_m = first;
      if (second >= 0) begin
        serve($sformatf("rnd%0d_b", ep), second, ar[second], rom[a1[second]] * rom[a2[second]], 7);
        @(posedge clk); #1;
        drop(second);
        last_m = second;
      end
    end

`ifdef MULJOB_CNT_EN
    // 257 back-to-back jobs: the counter wraps through zero to one.
    do_reset();
    check("cnt_reset", int'(job_cnt), 0);
    set_job(0, 1, 2, 5);
    for (int j = 0; j < 257; j++) serve($sformatf("cnt%0d", j), 0, 5, 6, 7);
    @(posedge clk); #1;
    check("cnt_wrap", int'(job_cnt), 1);
    drop(0);
`endif

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mul_job_sched.md
# mul_job_sched

Round-robin scheduler and sequencer for the shared ROM–multiplier–RAM datapath. Two requesters each submit a job of two ROM operand addresses and a RAM destination address. The block grants one job at a time and reads both operands from the synchronous ROM. It then registers their product and writes it to RAM, pulsing a per-requester `done`. It sits between the top-level `main` and the ROM/RAM instances, replacing the single-job sequencing with arbitrated sharing.

## Interface
- `DW`, 4, ROM data width (operand width); product width is 2*DW
- `AW`, 3, ROM and RAM address width
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `req0`, `req1`  in  1  job request from requester 0 / 1
- `adr1_0`, `adr2_0`, `adr_ram_0`  in  AW  requester-0 operand A, operand B and destination addresses
- `adr1_1`, `adr2_1`, `adr_ram_1`  in  AW  requester-1 operand A, operand B and destination addresses
- `done0`, `done1`  out  1  one-cycle completion pulse to the granted requester
- `rom_adr`  out  AW  ROM read address; ROM data is valid on the cycle after the address
- `rom_data`  in  DW  ROM read data
- `ram_we`  out  1  RAM write enable
- `ram_adr`  out  AW  RAM write address
- `ram_din`  out  2*DW  RAM write data
- `product`  out  2*DW  last registered product
- `st_out`  out  4  current FSM state encoding
- `job_cnt`  out  8  completed-job count; present only with `MULJOB_CNT_EN`

## Operation
- The states and `st_out` encodings are IDLE=0, RD1=1, RD2=2, LATCH=3, MUL=4, WR=5, DONE=6. Encodings 7–15 are unused and recover to IDLE.
- **IDLE**
  - If `req0` or `req1` is high, pick the winner.
  - If only one request is high, it wins.
  - If both are high, the winner is the requester not equal to `last`. `last` resets to 1, so requester 0 wins the first tie.
  - Latch the winner's three addresses and its id into `own`, set `last` to the winner, and go to RD1.
  - If no request is high, stay in IDLE.
- **RD1**: `rom_adr` = latched adr1.
- **RD2**: `rom_adr` = latched adr2. `op1` captures `rom_data` at the end of the cycle.
- **LATCH**: `op2` captures `rom_data`.
- **MUL**: `product` is registered as `op1*op2`, unsigned, full 2*DW bits, with no truncation.
- **WR**: `ram_we`=1, `ram_adr` = latched adr_ram, `ram_din` = `product`. This is the only cycle in which `ram_we` is high.
- **DONE**: `done<own>`=1 for exactly one cycle, then go to IDLE.
- **Requester rule**
  - A requester keeps its addresses stable while its `req` is high.
  - It must drop `req` at the edge on which it samples its `done` high.
  - Addresses are latched in IDLE, so later changes do not affect a job in flight.
- A request that is still high in IDLE after DONE is treated as a new job.
- In all non-read states, `rom_adr` is 0.

## Timing
- **Reset values**: state IDLE, `st_out`=0, `done0`/`done1`=0, `ram_we`=0, `rom_adr`/`ram_adr`/`ram_din`=0, `product`=0, `op1`/`op2`=0, `last`=1, `job_cnt`=0.
- **Job latency**: the grant edge leaves IDLE; `done` is high in the 6th cycle after it; the write happens in the 5th cycle.
- **Throughput**: one job per 7 cycles while requests are continuous. With both requesters continuously requesting, grants alternate 0,1,0,1,…
- **Reset mid-job**: asynchronous return to IDLE and all outputs go to their reset values immediately.
  - The in-flight job is dropped: no RAM write and no `done`.
  - A requester that holds `req` is re-served after reset is released.
- `ram_we` and `done` are never high in the same cycle.

## Configuration
- **`MULJOB_CNT_EN` defined**
  - The `job_cnt` port exists.
  - It increments by 1 on each DONE cycle and wraps from 255 to 0.
- **`MULJOB_CNT_EN` not defined**: no counter and no `job_cnt` port. All other behaviour is identical.

## Test plan
- The bench ROM model holds `rom[i]=i+1`.
- **Single job**: `req0`, adr1=1, adr2=2, adr_ram=5.
  - Response: `st_out` runs 1,2,3,4,5,6,0.
  - `ram_we` is high for one cycle with `ram_adr`=5 and `ram_din`=6.
  - `product`=6.
  - `done0` is pulsed 6 cycles after the grant; `done1` stays 0.
- **Simultaneous requests after reset**
  - Stimulus: `req0` with (2,5,7) and `req1` with (4,6,1), both continuous.
  - Requester 0 is served first and writes 18 to address 7.
  - Requester 1 is served next and writes 35 to address 1.
  - Service then alternates.
- **Maximum operands**: ROM entries set to 15, 15.
  - Response: `ram_din`=225 (8'hE1), with no truncation.
- **Reset during MUL**
  - Stimulus: `rst` pulsed asynchronously while `st_out`=4.
  - Response: outputs are zero immediately, no `ram_we`, no `done`.
  - With `req0` still high, the job is re-run and completes normally.
- **Address change mid-job**
  - Stimulus: `adr_ram_0` changed from 5 to 3 during RD2.
  - Response: the write still goes to address 5.
- **`MULJOB_CNT_EN` defined**
  - Stimulus: 257 back-to-back jobs.
  - Response: `job_cnt` reads 1 after the final DONE (wraps from 255 to 0).
  - Without the macro, the build succeeds with no `job_cnt` port.
